uart_time_reporter: RTL and testbench

Sequencer and arbiter for the single UART transmitter shared by echoed receive bytes and time reports. On a report request it snapshots the currently displayed time (hour/min/sec/centisecond from the stopwatch/clock mode mux) and serializes it as the 13-byte ASCII frame "HH:MM:SS.CC\r\n". Between frames it forwards echo bytes through a one-deep buffer. It sits between the UART command decoder / RX path and the UART TX.

---
 rtl/uart_time_reporter.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_time_reporter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_time_reporter.sv
// Purpose: shares one UART TX between echoed RX bytes and 13-byte "HH:MM:SS.CC\r\n" time frames.
// Latency: a request or echo in cycle N with the block idle and TX free gives tx_start in cycle N+2.
// Backpressure: waits for tx_busy low before each byte; a frame is atomic; a one-deep echo buffer overflows with echo_drop.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   report_req            one-cycle request for a time frame (ignored while report_busy)
//   hour/min/sec/msec     displayed time, snapshotted on report accept
//   echo_valid/echo_data  one-cycle strobe carrying a byte to echo
//   tx_busy               UART TX is shifting a byte
//   tx_start/tx_data      one-cycle start strobe and held byte to the UART TX
//   report_busy           a report is pending or being sent
//   echo_drop             one-cycle pulse: an echo byte was discarded
module uart_time_reporter (
    input  logic       clk,
    input  logic       rst,
    input  logic       report_req,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [6:0] msec,
    input  logic       echo_valid,
    input  logic [7:0] echo_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       report_busy,
    output logic       echo_drop
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    typedef enum logic {
        SRC_ECHO   = 1'b0,
        SRC_REPORT = 1'b1
    } src_t;

    localparam logic [3:0] LAST_IDX = 4'd12;

    state_t     r_state;
    src_t       r_src;
    logic [3:0] r_idx;
    logic [7:0] r_tx_data;

    logic       r_pend;
    logic       r_report_busy;
    logic [6:0] r_hour;
    logic [6:0] r_min;
    logic [6:0] r_sec;
    logic [6:0] r_csec;

    logic       r_buf_vld;
    logic [7:0] r_buf_dat;
    logic       r_echo_drop;

    state_t     w_state_nxt;
    src_t       w_src_nxt;
    logic [3:0] w_idx_nxt;
    logic       w_load;
    logic [7:0] w_load_dat;
    logic       w_frame_done;
    logic [3:0] w_sel_idx;
    logic [7:0] w_frame_byte;
    logic       w_accept;
    logic       w_rpt_take;
    logic       w_drain;

    function automatic logic [6:0] clamp99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    function automatic logic [7:0] ascii_tens(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return 8'h30 + {1'b0, t};
    endfunction

    function automatic logic [7:0] ascii_ones(input logic [6:0] v);
        logic [6:0] t;
        t = v % 7'd10;
        return 8'h30 + {1'b0, t};
    endfunction

    assign w_accept   = report_req && !r_report_busy;
    assign w_rpt_take = (r_state == S_SEND) && (r_src == SRC_REPORT) && (r_idx == 4'd0);
    assign w_drain    = (r_state == S_SEND) && (r_src == SRC_ECHO);

    // The byte to load is chosen one cycle ahead of SEND: index 0 when
    // leaving IDLE, the next index when leaving WAIT mid-frame.
    assign w_sel_idx = (r_state == S_WAIT) ? (r_idx + 4'd1) : 4'd0;

    always_comb begin
        w_frame_byte = 8'h00;
        case (w_sel_idx)
            4'd0:    w_frame_byte = ascii_tens(r_hour);
            4'd1:    w_frame_byte = ascii_ones(r_hour);
            4'd2:    w_frame_byte = 8'h3A;
            4'd3:    w_frame_byte = ascii_tens(r_min);
            4'd4:    w_frame_byte = ascii_ones(r_min);
            4'd5:    w_frame_byte = 8'h3A;
            4'd6:    w_frame_byte = ascii_tens(r_sec);
            4'd7:    w_frame_byte = ascii_ones(r_sec);
            4'd8:    w_frame_byte = 8'h2E;
            4'd9:    w_frame_byte = ascii_tens(r_csec);
            4'd10:   w_frame_byte = ascii_ones(r_csec);
            4'd11:   w_frame_byte = 8'h0D;
            4'd12:   w_frame_byte = 8'h0A;
            default: w_frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_src_nxt    = r_src;
        w_idx_nxt    = r_idx;
        w_load       = 1'b0;
        w_load_dat   = 8'h00;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!tx_busy) begin
                    if (r_buf_vld) begin
                        w_state_nxt = S_SEND;
                        w_src_nxt   = SRC_ECHO;
                        w_load      = 1'b1;
                        w_load_dat  = r_buf_dat;
                    end else if (r_pend) begin
                        w_state_nxt = S_SEND;
                        w_src_nxt   = SRC_REPORT;
                        w_idx_nxt   = 4'd0;
                        w_load      = 1'b1;
                        w_load_dat  = w_frame_byte;
                    end
                end
            end
            S_SEND: w_state_nxt = S_GAP;
            // TX busy is registered on its side, so it is not yet valid here.
            S_GAP:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) begin
                    if (r_src == SRC_REPORT) begin
                        if (r_idx < LAST_IDX) begin
                            w_state_nxt = S_SEND;
                            w_idx_nxt   = r_idx + 4'd1;
                            w_load      = 1'b1;
                            w_load_dat  = w_frame_byte;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_frame_done = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_src     <= SRC_ECHO;
            r_idx     <= 4'd0;
            r_tx_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_idx   <= w_idx_nxt;
            if (w_load) begin
                r_tx_data <= w_load_dat;
            end
        end
    end

    // Report request, snapshot and busy flag. Requests while busy coalesce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend        <= 1'b0;
            r_report_busy <= 1'b0;
            r_hour        <= 7'd0;
            r_min         <= 7'd0;
            r_sec         <= 7'd0;
            r_csec        <= 7'd0;
        end else if (w_accept) begin
            r_pend        <= 1'b1;
            r_report_busy <= 1'b1;
            r_hour        <= clamp99({2'b00, hour});
            r_min         <= clamp99({1'b0, min});
            r_sec         <= clamp99({1'b0, sec});
            r_csec        <= clamp99(msec);
        end else begin
            if (w_rpt_take) begin
                r_pend <= 1'b0;
            end
            if (w_frame_done) begin
                r_report_busy <= 1'b0;
            end
        end
    end

    // One-deep echo buffer. A byte arriving on the drain cycle refills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_vld   <= 1'b0;
            r_buf_dat   <= 8'h00;
            r_echo_drop <= 1'b0;
        end else begin
            r_echo_drop <= 1'b0;
            if (echo_valid) begin
                if (!r_buf_vld || w_drain) begin
                    r_buf_vld <= 1'b1;
                    r_buf_dat <= echo_data;
                end else begin
                    r_echo_drop <= 1'b1;
                end
            end else if (w_drain) begin
                r_buf_vld <= 1'b0;
            end
        end
    end

    assign tx_start    = (r_state == S_SEND);
    assign tx_data     = r_tx_data;
    assign report_busy = r_report_busy;
    assign echo_drop   = r_echo_drop;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Purpose: directed self-checking bench for uart_time_reporter with a simple busy-counting TX.
// Latency: expected bytes are queued in transmit order; every tx_start is matched against that queue.
// Backpressure: the TX stand-in holds tx_busy for busy_len cycles after each tx_start.
module tb_uart_time_reporter;

    logic       clk;
    logic       rst;
    logic       report_req;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] msec;
    logic       echo_valid;
    logic [7:0] echo_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       report_busy;
    logic       echo_drop;

    uart_time_reporter dut (
        .clk         (clk),
        .rst         (rst),
        .report_req  (report_req),
        .hour        (hour),
        .min         (min),
        .sec         (sec),
        .msec        (msec),
        .echo_valid  (echo_valid),
        .echo_data   (echo_data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .report_busy (report_busy),
        .echo_drop   (echo_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    int last_start_cyc = -100;
    int start_cnt = 0;
    int drop_seen = 0;
    int exp_drop = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] cap[$];
    logic [7:0] lit [13] = '{8'h31, 8'h33, 8'h3A, 8'h30, 8'h37, 8'h3A, 8'h34,
                             8'h32, 8'h2E, 8'h30, 8'h35, 8'h0D, 8'h0A};

    always @(posedge clk) cyc <= cyc + 1;

    // TX stand-in: busy for busy_len cycles starting the cycle after tx_start.
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected frame from plain arithmetic on the requested time.
    task automatic push_frame(input int h, input int m, input int s, input int c);
        int v[4];
        v[0] = h; v[1] = m; v[2] = s; v[3] = c;
        for (int i = 0; i < 4; i++) begin
            if (v[i] > 99) v[i] = 99;
            exp_q.push_back(8'(48 + v[i] / 10));
            exp_q.push_back(8'(48 + v[i] % 10));
            if (i == 0 || i == 1) exp_q.push_back(8'h3A);
            if (i == 2) exp_q.push_back(8'h2E);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Single compare process: every tx_start is matched to the model queue.
    always @(negedge clk) begin
        if (rst) begin
            last_data = 8'h00;
        end else begin
            if (tx_start) begin
                start_cnt++;
                check("start_spacing", 32'(cyc - last_start_cyc >= 3), 1);
                check("start_while_busy", {31'd0, prev_busy}, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_tx_start actual=%h required=no start (t=%0t)", tx_data, $time);
                end else begin
                    check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                cap.push_back(tx_data);
                last_start_cyc = cyc;
                last_data = tx_data;
            end else begin
                check("tx_data_hold", {24'd0, tx_data}, {24'd0, last_data});
            end
            if (echo_drop) drop_seen++;
        end
        prev_busy = tx_busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_queue_left", exp_q.size(), 0);
        repeat (busy_len + 6) tick();
        check("report_busy_after_drain", {31'd0, report_busy}, 0);
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
    endtask

    initial begin
        int n;
        int fall_cyc;
        int first_cyc;
        int base;
        rst = 1'b1; report_req = 1'b0; echo_valid = 1'b0; echo_data = 8'h00;
        set_time(0, 0, 0, 0);
        repeat (3) tick();
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_report_busy", {31'd0, report_busy}, 0);
        check("rst_echo_drop", {31'd0, echo_drop}, 0);
        rst = 1'b0;
        tick();

        // Basic frame, snapshot integrity, coalesced second request.
        busy_len = 10;
        cap.delete();
        set_time(13, 7, 42, 5);
        report_req = 1'b1;
        push_frame(13, 7, 42, 5);
        tick();
        report_req = 1'b0;
        set_time(0, 0, 0, 0);
        check("basic_n1_tx_start", {31'd0, tx_start}, 0);
        check("basic_n1_report_busy", {31'd0, report_busy}, 1);
        tick();
        check("basic_n2_tx_start", {31'd0, tx_start}, 1);
        check("basic_n2_tx_data", {24'd0, tx_data}, 32'h31);
        repeat (30) tick();
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        n = 0;
        while (report_busy && n < 400) begin
            tick();
            n++;
        end
        fall_cyc = cyc;
        check("basic_busy_fall_seen", {31'd0, report_busy}, 0);
        check("basic_busy_fall_cycle", 32'(fall_cyc - last_start_cyc), 12);
        wait_drain(100);
        check("basic_byte_count", cap.size(), 13);
        for (int i = 0; i < 13; i++)
            if (i < cap.size()) check("basic_literal_byte", {24'd0, cap[i]}, {24'd0, lit[i]});

        // Echo and report together: echo first, then frame; mid-frame echo after frame.
        set_time(23, 59, 59, 99);
        report_req = 1'b1; echo_valid = 1'b1; echo_data = 8'h41;
        exp_q.push_back(8'h41);
        push_frame(23, 59, 59, 99);
        tick();
        report_req = 1'b0; echo_valid = 1'b0;
        tick();
        check("arb_n2_tx_start", {31'd0, tx_start}, 1);
        check("arb_n2_tx_data", {24'd0, tx_data}, 32'h41);
        repeat (40) tick();
        check("arb_mid_report_busy", {31'd0, report_busy}, 1);
        echo_valid = 1'b1; echo_data = 8'h42;
        exp_q.push_back(8'h42);
        tick();
        echo_valid = 1'b0;
        wait_drain(400);

        // Echo overflow during a frame.
        set_time(1, 2, 3, 4);
        report_req = 1'b1;
        push_frame(1, 2, 3, 4);
        tick();
        report_req = 1'b0;
        repeat (30) tick();
        echo_valid = 1'b1; echo_data = 8'h43;
        exp_q.push_back(8'h43);
        tick();
        check("ovf_first_no_drop", {31'd0, echo_drop}, 0);
        echo_data = 8'h44;
        exp_drop++;
        tick();
        echo_valid = 1'b0;
        check("ovf_drop_pulse", {31'd0, echo_drop}, 1);
        tick();
        check("ovf_drop_single", {31'd0, echo_drop}, 0);
        wait_drain(400);

        // Clamp and minimum spacing with an always-free TX.
        busy_len = 0;
        set_time(5, 6, 7, 120);
        report_req = 1'b1;
        push_frame(5, 6, 7, 120);
        tick();
        report_req = 1'b0;
        tick();
        check("clamp_n2_tx_start", {31'd0, tx_start}, 1);
        check("clamp_n2_tx_data", {24'd0, tx_data}, 32'h30);
        first_cyc = cyc;
        n = 0;
        while (report_busy && n < 200) begin
            tick();
            n++;
        end
        check("clamp_frame_span", 32'(last_start_cyc - first_cyc), 36);
        wait_drain(100);

        // Echo arriving on the drain cycle is kept.
        echo_valid = 1'b1; echo_data = 8'h45;
        exp_q.push_back(8'h45);
        tick();
        echo_valid = 1'b0;
        tick();
        check("drain_n2_tx_start", {31'd0, tx_start}, 1);
        echo_valid = 1'b1; echo_data = 8'h46;
        exp_q.push_back(8'h46);
        tick();
        echo_valid = 1'b0;
        check("drain_no_drop", {31'd0, echo_drop}, 0);
        wait_drain(100);

        // Reset mid-frame.
        busy_len = 10;
        set_time(12, 34, 56, 78);
        report_req = 1'b1;
        push_frame(12, 34, 56, 78);
        tick();
        report_req = 1'b0;
        base = start_cnt;
        n = 0;
        while (start_cnt < base + 4 && n < 300) begin
            tick();
            n++;
        end
        check("rstmid_four_bytes", start_cnt - base, 4);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("rstmid_tx_start", {31'd0, tx_start}, 0);
        check("rstmid_tx_data", {24'd0, tx_data}, 0);
        check("rstmid_report_busy", {31'd0, report_busy}, 0);
        check("rstmid_echo_drop", {31'd0, echo_drop}, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        base = start_cnt;
        repeat (60) tick();
        check("rstmid_no_start", start_cnt - base, 0);
        check("rstmid_idle_busy", {31'd0, report_busy}, 0);
        set_time(9, 8, 7, 6);
        report_req = 1'b1;
        push_frame(9, 8, 7, 6);
        tick();
        report_req = 1'b0;
        wait_drain(400);

        check("echo_drop_count", drop_seen, exp_drop);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
